// File: rtl/bf_pkg.sv
// Shared definitions for the shortest-path result walker.
//   bf_state_e : controller state encoding
//   ERR_*      : error codes reported on the err port
//   hop_cnt_w  : width of a hop counter able to hold 0..max_hops
package bf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_DEST_WAIT = 3'd3,
    ST_RD        = 3'd4,
    ST_WALK      = 3'd5,
    ST_DISPLAY   = 3'd6,
    ST_ERROR     = 3'd7
  } bf_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNREACH = 2'd1;
  localparam logic [1:0] ERR_LOOP    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic int hop_cnt_w(input int max_hops);
    return (max_hops < 1) ? 1 : $clog2(max_hops + 1);
  endfunction

endpackage

// File: rtl/bf_walk_timer.sv
// Per-hop read-latency wait counter and hop counter for the path walk.
//   clk, rst_n : clock and active-low async reset (already synchronised)
//   load       : first hop issued (RD): wait restarts at 1, hop count = 1
//   adv        : hop accepted in WALK: wait restarts at 1, hop count + 1
//   tick       : WALK cycle, advances the wait counter
//   wait_done  : read data for the current hop is valid this cycle
//   hop_cnt    : number of nodes strobed so far in this walk
module bf_walk_timer
  import bf_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int HOP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  input  logic             tick,
  output logic             wait_done,
  output logic [HOP_W-1:0] hop_cnt
);

  logic [2:0]       wait_q, wait_d;
  logic [HOP_W-1:0] hop_q, hop_d;

  // The wait counter names the cycle within the hop (1..RD_LAT); the
  // address was issued the cycle before cycle 1, so data lands on RD_LAT.
  always_comb begin
    wait_d = wait_q;
    hop_d  = hop_q;
    if (load) begin
      wait_d = 3'd1;
      hop_d  = HOP_W'(1);
    end else if (adv) begin
      wait_d = 3'd1;
      hop_d  = hop_q + HOP_W'(1);
    end else if (tick) begin
      wait_d = wait_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      hop_q  <= '0;
    end else begin
      wait_q <= wait_d;
      hop_q  <= hop_d;
    end
  end

  assign wait_done = (wait_q == 3'(RD_LAT));
  assign hop_cnt   = hop_q;

endmodule

// File: rtl/bf_path_ctrl.sv
// Controller that runs a shortest-path engine and then walks its
// predecessor memory from a destination back to the source, strobing
// each node for display.
//   CLOCK_50, KEY     : clock, async active-low reset (release synchronised)
//   abort             : soft return to IDLE
//   start/src_in      : begin a compute from a new source
//   new_dest/dst_in   : request a path walk to a destination
//   eng_*             : engine clear/enable/converged handshake
//   pred_*            : predecessor memory read port (RD_LAT latency)
//   path_*            : emitted path nodes, path_last on the source
//   disp_clr/disp_on  : display control
//   err, busy         : error code and activity status
module bf_path_ctrl
  import bf_pkg::*;
#(
  parameter int NODE_W     = 5,
  parameter int RD_LAT     = 1,
  parameter int MAX_HOPS   = 2**NODE_W - 1,
  parameter int COMPUTE_TO = 4096
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  input  logic              abort,
  input  logic              start,
  input  logic [NODE_W-1:0] src_in,
  input  logic              new_dest,
  input  logic [NODE_W-1:0] dst_in,
  output logic              eng_clear,
  output logic              eng_en,
  input  logic              eng_done,
  output logic              pred_sel,
  output logic [NODE_W-1:0] pred_addr,
  input  logic [NODE_W-1:0] pred_out,
  input  logic              pred_vld,
  output logic [NODE_W-1:0] path_node,
  output logic              path_valid,
  output logic              path_last,
  output logic              disp_clr,
  output logic              disp_on,
  output logic [1:0]        err,
  output logic              busy
);

  localparam int HOP_W = hop_cnt_w(MAX_HOPS);
  localparam int TO_W  = (COMPUTE_TO > 1) ? $clog2(COMPUTE_TO) : 1;
  localparam logic [HOP_W-1:0] HOP_MAX = HOP_W'(MAX_HOPS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(COMPUTE_TO - 1);

  // Reset asserts asynchronously but releases two edges after KEY rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) rst_sync_q <= 2'b00;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  bf_state_e         state_q, state_d;
  logic [NODE_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [1:0]        err_q, err_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              tm_load, tm_adv, tm_tick, wait_done;
  logic [HOP_W-1:0]  hop_cnt;

  bf_walk_timer #(
    .RD_LAT (RD_LAT),
    .HOP_W  (HOP_W)
  ) u_timer (
    .clk       (CLOCK_50),
    .rst_n     (rst_n),
    .load      (tm_load),
    .adv       (tm_adv),
    .tick      (tm_tick),
    .wait_done (wait_done),
    .hop_cnt   (hop_cnt)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    addr_d     = addr_q;
    err_d      = err_q;
    to_d       = to_q;
    tm_load    = 1'b0;
    tm_adv     = 1'b0;
    tm_tick    = 1'b0;
    eng_clear  = 1'b0;
    eng_en     = 1'b0;
    pred_sel   = 1'b0;
    pred_addr  = '0;
    path_node  = '0;
    path_valid = 1'b0;
    path_last  = 1'b0;
    disp_clr   = 1'b0;
    disp_on    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_in;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        eng_clear = 1'b1;
        to_d      = '0;
        state_d   = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        eng_en = 1'b1;
        if (eng_done) begin
          state_d = ST_DEST_WAIT;
        end else if (to_q == TO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_ERROR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_DEST_WAIT: begin
        if (new_dest) begin
          dst_d   = dst_in;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        pred_sel   = 1'b1;
        pred_addr  = dst_q;
        path_valid = 1'b1;
        path_node  = dst_q;
        disp_clr   = 1'b1;
        tm_load    = 1'b1;
        addr_d     = dst_q;
        if (dst_q == src_q) begin
          path_last = 1'b1;
          state_d   = ST_DISPLAY;
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        pred_sel  = 1'b1;
        pred_addr = addr_q;
        tm_tick   = 1'b1;
        if (wait_done) begin
          if (!pred_vld) begin
            err_d   = ERR_UNREACH;
            state_d = ST_ERROR;
          end else if (pred_out == src_q) begin
            path_valid = 1'b1;
            path_node  = pred_out;
            path_last  = 1'b1;
            state_d    = ST_DISPLAY;
          end else if (hop_cnt >= HOP_MAX) begin
            err_d   = ERR_LOOP;
            state_d = ST_ERROR;
          end else begin
            // Issue the next read in the same cycle the hop is emitted so
            // every hop costs exactly RD_LAT cycles.
            path_valid = 1'b1;
            path_node  = pred_out;
            pred_addr  = pred_out;
            addr_d     = pred_out;
            tm_adv     = 1'b1;
          end
        end
      end
      ST_DISPLAY: begin
        disp_on = 1'b1;
        if (start) begin
          src_d   = src_in;
          state_d = ST_INIT;
        end else if (new_dest) begin
          dst_d   = dst_in;
          state_d = ST_RD;
        end
      end
      ST_ERROR: begin
        if (start) begin
          src_d   = src_in;
          err_d   = ERR_NONE;
          state_d = ST_INIT;
        end else if (new_dest && (err_q != ERR_TIMEOUT)) begin
          dst_d   = dst_in;
          err_d   = ERR_NONE;
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      err_d   = ERR_NONE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      err_q   <= ERR_NONE;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign err  = err_q;
  assign busy = !((state_q == ST_IDLE) || (state_q == ST_DISPLAY) ||
                  (state_q == ST_ERROR));

endmodule

// File: tb/tb_bf_path_ctrl.sv
// Randomised self-checking bench for bf_path_ctrl with a queue-based
// reference model of the predecessor walk.
module tb_bf_path_ctrl;

  localparam int NW  = 5;
  localparam int LAT = 3;
  localparam int MH  = 4;
  localparam int CTO = 16;

  logic          CLOCK_50 = 1'b0;
  logic          KEY      = 1'b0;
  logic          abort    = 1'b0;
  logic          start    = 1'b0;
  logic          new_dest = 1'b0;
  logic          eng_done = 1'b0;
  logic [NW-1:0] src_in   = '0;
  logic [NW-1:0] dst_in   = '0;
  logic          eng_clear, eng_en, pred_sel, path_valid, path_last;
  logic          disp_clr, disp_on, busy, pred_vld;
  logic [NW-1:0] pred_addr, pred_out, path_node;
  logic [1:0]    err;

  always #5 CLOCK_50 = ~CLOCK_50;

  bf_path_ctrl #(
    .NODE_W     (NW),
    .RD_LAT     (LAT),
    .MAX_HOPS   (MH),
    .COMPUTE_TO (CTO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .KEY        (KEY),
    .abort      (abort),
    .start      (start),
    .src_in     (src_in),
    .new_dest   (new_dest),
    .dst_in     (dst_in),
    .eng_clear  (eng_clear),
    .eng_en     (eng_en),
    .eng_done   (eng_done),
    .pred_sel   (pred_sel),
    .pred_addr  (pred_addr),
    .pred_out   (pred_out),
    .pred_vld   (pred_vld),
    .path_node  (path_node),
    .path_valid (path_valid),
    .path_last  (path_last),
    .disp_clr   (disp_clr),
    .disp_on    (disp_on),
    .err        (err),
    .busy       (busy)
  );

  // Predecessor memory: table plus an LAT-deep address pipeline.
  logic [NW-1:0] pm [32];
  logic          pv [32];
  logic [NW-1:0] apipe [LAT];

  always @(posedge CLOCK_50) begin
    apipe[0] <= pred_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end

  assign pred_out = pm[apipe[LAT-1]];
  assign pred_vld = pv[apipe[LAT-1]];

  // Monitor: sampled on the falling edge.
  int            cyc = 0;
  logic [NW-1:0] obs_node [$];
  logic          obs_last [$];
  int            obs_cyc [$];
  int            en_cnt = 0, sel_cnt = 0, clr_cnt = 0, zero_bad = 0;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (path_valid) begin
      obs_node.push_back(path_node);
      obs_last.push_back(path_last);
      obs_cyc.push_back(cyc);
    end else if (path_node != '0) begin
      zero_bad++;
    end
    if (eng_en)   en_cnt++;
    if (pred_sel) sel_cnt++;
    if (disp_clr) clr_cnt++;
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Reference: walk the table from d toward s under the hop limit.
  logic [NW-1:0] exp_q [$];
  int            exp_err;
  logic [NW-1:0] src_cur;

  task automatic model_path(input logic [NW-1:0] s, input logic [NW-1:0] d);
    logic [NW-1:0] n;
    exp_q.delete();
    exp_err = 0;
    exp_q.push_back(d);
    n = d;
    if (d == s) return;
    forever begin
      if (!pv[n]) begin exp_err = 1; return; end
      if (pm[n] == s) begin exp_q.push_back(pm[n]); return; end
      if (exp_q.size() + 1 > MH) begin exp_err = 2; return; end
      exp_q.push_back(pm[n]);
      n = pm[n];
    end
  endtask

  task automatic pulse_start(input logic [NW-1:0] s);
    start  = 1'b1;
    src_in = s;
    step();
    start  = 1'b0;
  endtask

  task automatic do_compute(input string tag, input logic [NW-1:0] s,
                            input int delay);
    int k, eb;
    pulse_start(s);
    src_cur = s;
    k = 0;
    while (!eng_en && k < 20) begin step(); k++; end
    eb = en_cnt;
    repeat (delay) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check_eq({tag, "_en_cycles"}, en_cnt - eb, delay + 1);
    check_eq({tag, "_destwait"}, {busy, eng_en, err}, 4'b1000);
  endtask

  task automatic run_dest(input string tag, input logic [NW-1:0] d);
    int b, sb, cb, k, n;
    b  = obs_node.size();
    sb = sel_cnt;
    cb = clr_cnt;
    model_path(src_cur, d);
    new_dest = 1'b1;
    dst_in   = d;
    step();
    new_dest = 1'b0;
    k = 0;
    while (busy && k < 200) begin step(); k++; end
    check_eq({tag, "_finished"}, busy, 0);
    n = obs_node.size() - b;
    check_eq({tag, "_strobes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < obs_node.size()) begin
        check_eq({tag, "_node"}, obs_node[b+i], exp_q[i]);
        check_eq({tag, "_last"}, obs_last[b+i],
                 (i == exp_q.size() - 1) && (exp_err == 0));
        if (i > 0) check_eq({tag, "_gap"}, obs_cyc[b+i] - obs_cyc[b+i-1], LAT);
      end
    end
    check_eq({tag, "_err"}, err, exp_err);
    check_eq({tag, "_disp_on"}, disp_on, exp_err == 0);
    check_eq({tag, "_sel_cycles"}, sel_cnt - sb,
             1 + LAT * (exp_q.size() - 1 + ((exp_err != 0) ? 1 : 0)));
    check_eq({tag, "_disp_clr"}, clr_cnt - cb, 1);
  endtask

  task automatic set_identity();
    for (int i = 0; i < 32; i++) begin
      pm[i] = NW'(i);
      pv[i] = 1'b1;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, eng_clear, eng_en, pred_sel, pred_addr, path_node,
            path_valid, path_last, disp_clr, disp_on, err, busy};
  endfunction

  initial begin
    int k, eb, sb;
    logic [NW-1:0] s, d;
    set_identity();

    // Reset state and synchronised release.
    repeat (3) step();
    check_eq("reset_outputs", all_outs(), 0);
    KEY    = 1'b1;
    start  = 1'b1;
    src_in = 5'd3;
    step();
    step();
    start  = 1'b0;
    check_eq("reset_release_sync", {busy, eng_clear}, 0);
    step();
    step();

    // Chain 9 -> 7 -> 3.
    pm[9] = 5'd7;
    pm[7] = 5'd3;
    do_compute("chain_c", 5'd3, 4);
    run_dest("chain", 5'd9);

    // Same node: no walk.
    do_compute("same_c", 5'd4, 2);
    run_dest("same", 5'd4);

    // Unreachable at node 7, then retry from ERROR without recompute.
    do_compute("unr_c", 5'd3, 0);
    pv[7] = 1'b0;
    run_dest("unreach", 5'd9);
    pv[7] = 1'b1;
    run_dest("err_to_rd", 5'd9);

    // Loop 9 <-> 7, then abort out of ERROR.
    pm[7] = 5'd9;
    do_compute("loop_c", 5'd3, 1);
    run_dest("loop", 5'd9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_idle", {busy, disp_on, err}, 0);

    // Timeout: eng_done held low.
    pulse_start(5'd3);
    src_cur = 5'd3;
    eb = en_cnt;
    k = 0;
    while (err == 2'd0 && k < 100) begin step(); k++; end
    check_eq("to_cycles", en_cnt - eb, CTO);
    check_eq("to_err", err, 3);
    check_eq("to_busy", busy, 0);
    sb = sel_cnt;
    new_dest = 1'b1;
    dst_in   = 5'd9;
    step();
    new_dest = 1'b0;
    step();
    check_eq("to_newdest_ignored", {err, busy, 4'(sel_cnt - sb)}, {2'd3, 1'b0, 4'd0});
    pulse_start(5'd3);
    check_eq("to_restart", {eng_clear, err}, 3'b100);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;

    // Start and new_dest together in DISPLAY: start wins.
    pm[7] = 5'd3;
    run_dest("conc_pre", 5'd9);
    start    = 1'b1;
    src_in   = 5'd3;
    new_dest = 1'b1;
    dst_in   = 5'd9;
    step();
    start    = 1'b0;
    new_dest = 1'b0;
    check_eq("conc_start_wins", {eng_clear, disp_clr, pred_sel}, 3'b100);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;

    // KEY low mid-WALK, then a clean restart.
    new_dest = 1'b1;
    dst_in   = 5'd9;
    step();
    new_dest = 1'b0;
    step();
    step();
    check_eq("midwalk_in_walk", {busy, pred_sel}, 2'b11);
    KEY = 1'b0;
    #1;
    check_eq("midwalk_async_reset", all_outs(), 0);
    step();
    step();
    KEY = 1'b1;
    repeat (3) step();
    check_eq("midwalk_idle", all_outs(), 0);
    do_compute("rst_c", 5'd3, 3);
    run_dest("after_reset", 5'd9);

    // Randomised tables, sources and destinations.
    for (int it = 0; it < 25; it++) begin
      s = NW'($urandom_range(0, 31));
      for (int i = 0; i < 32; i++) begin
        pv[i] = ($urandom_range(0, 7) != 0);
        pm[i] = ($urandom_range(0, 2) == 0) ? s : NW'($urandom_range(0, 31));
      end
      do_compute("rnd_c", s, $urandom_range(0, 10));
      for (int j = 0; j < 2; j++) begin
        d = ($urandom_range(0, 5) == 0) ? s : NW'($urandom_range(0, 31));
        run_dest("rnd", d);
      end
    end

    check_eq("path_node_zero_when_idle", zero_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bf_path_ctrl.md
BF_PATH_CTRL -- requirements
Module: bf_path_ctrl

Interface
REQ-001 Parameter NODE_W, default 5: width of every node address.
REQ-002 Parameter RD_LAT, default 1: predecessor-memory read latency in cycles, 1..4.
REQ-003 Parameter MAX_HOPS, default 2**NODE_W - 1: maximum path nodes emitted before a loop error is declared.
REQ-004 Parameter COMPUTE_TO, default 4096: maximum COMPUTE cycles before a timeout error is declared.
REQ-005 Port CLOCK_50, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port KEY, input, 1: asynchronous active-low reset.
REQ-007 Port abort, input, 1: synchronous soft return to IDLE.
REQ-008 Port start, input, 1: one-cycle pulse that latches src_in and begins a compute.
REQ-009 Port src_in, input, NODE_W: source node.
REQ-010 Port new_dest, input, 1: one-cycle pulse that latches dst_in and requests a path walk.
REQ-011 Port dst_in, input, NODE_W: destination node.
REQ-012 Port eng_clear, output, 1: engine clear, asserted in INIT only.
REQ-013 Port eng_en, output, 1: engine enable, asserted in COMPUTE only.
REQ-014 Port eng_done, input, 1: engine converged.
REQ-015 Port pred_sel, output, 1: selects the predecessor read port, asserted in RD and WALK.
REQ-016 Port pred_addr, output, NODE_W: predecessor read address.
REQ-017 Port pred_out, input, NODE_W: predecessor read data, valid RD_LAT cycles after pred_addr.
REQ-018 Port pred_vld, input, 1: the node has a predecessor, aligned with pred_out.
REQ-019 Port path_node, output, NODE_W: emitted path node.
REQ-020 Port path_valid, output, 1: one-cycle strobe per emitted node.
REQ-021 Port path_last, output, 1: marks the source node, the final strobe.
REQ-022 Port disp_clr, output, 1: display clear, a one-cycle pulse on entry to RD.
REQ-023 Port disp_on, output, 1: asserted in DISPLAY.
REQ-024 Port err, output, 2: error code — 0 none, 1 unreachable, 2 loop, 3 timeout.
REQ-025 Port busy, output, 1: high in every state except IDLE, DISPLAY and ERROR.

Function
REQ-026 The block shall implement the states IDLE, INIT, COMPUTE, DEST_WAIT, RD, WALK, DISPLAY and ERROR.
REQ-027 IDLE shall go to INIT on start, latching src_in into src_q.
REQ-028 INIT shall go to COMPUTE unconditionally after one cycle, and the timeout counter shall clear to 0.
REQ-029 COMPUTE shall go to DEST_WAIT on eng_done, and shall go to ERROR with err=3 when the counter reaches COMPUTE_TO-1 without eng_done.
REQ-030 If eng_done and timeout coincide, eng_done shall win.
REQ-031 DEST_WAIT shall go to RD on new_dest, latching dst_in into dst_q.
REQ-032 In RD, pred_addr shall equal dst_q and path_node=dst_q shall be strobed, with hop count 1.
REQ-033 If dst_q==src_q, RD shall assert path_last on that strobe and go to DISPLAY; otherwise it shall go to WALK.
REQ-034 WALK shall wait RD_LAT cycles per hop, then sample pred_out and pred_vld.
REQ-035 In WALK, pred_vld=0 shall go to ERROR with err=1.
REQ-036 In WALK, pred_out==src_q shall strobe it with path_last and go to DISPLAY.
REQ-037 In WALK, if hop count would exceed MAX_HOPS, the block shall go to ERROR with err=2 and emit no strobe.
REQ-038 Otherwise WALK shall strobe pred_out, drive pred_addr=pred_out, increment the hop count and repeat.
REQ-039 Unreachable shall take precedence over source-reached, which shall take precedence over the loop check.
REQ-040 pred_addr shall be held stable throughout each RD_LAT wait.
REQ-041 DISPLAY shall go to INIT on start (new source), else to RD on new_dest (new destination, no recompute).
REQ-042 When start and new_dest coincide in DISPLAY, start shall win.
REQ-043 ERROR shall hold err until the next transition; it shall go to INIT on start, or to RD on new_dest only when err is not 3.
REQ-044 err shall clear to 0 on leaving ERROR.
REQ-045 start shall be ignored in INIT, COMPUTE, DEST_WAIT, RD and WALK; new_dest shall be ignored outside DEST_WAIT, DISPLAY and ERROR.
REQ-046 abort shall move any state to IDLE on the next cycle, clearing err, with priority over all other inputs.
REQ-047 path_node shall be 0 whenever path_valid is low.

Reset
REQ-048 KEY low shall asynchronously force IDLE with all outputs 0, src_q=0, dst_q=0, hop count=0 and timeout counter=0.
REQ-049 Reset release shall be synchronised so that the first state change is no earlier than the second clock edge after KEY rises.

Structure
REQ-050 The state encoding, the err code constants and a helper function computing the hop-counter width from MAX_HOPS shall live in the shared package bf_pkg.
REQ-051 The RD_LAT wait counter and hop counter may be factored into the sub-module bf_walk_timer; the FSM shall stay in bf_path_ctrl.

Verification
REQ-052 Chain: defaults with src 3, dst 9, and preds 9->7, 7->3 -> strobes 9, 7, 3, with last on 3, then disp_on.
REQ-053 Same node: src=dst=4 -> a single strobe of 4 with path_last, and no WALK cycles.
REQ-054 Unreachable: pred_vld=0 at node 7 -> strobes 9, 7, then err=1 and busy low.
REQ-055 Loop: preds 9->7, 7->9 with MAX_HOPS=4 -> strobes 9, 7, 9, 7, then err=2.
REQ-056 Timeout: COMPUTE_TO=16 with eng_done held low -> err=3 on cycle 16 of COMPUTE; new_dest ignored, start re-enters INIT.
REQ-057 Concurrency and reset: start and new_dest together in DISPLAY -> INIT; KEY low mid-WALK with RD_LAT=3 -> IDLE immediately, and the next start restarts cleanly.
